// File: rtl/counter_pkg.sv
// Shared definitions for the counter family (up-counter and down-counter).
// Both counters use the same state encoding and default width, so they can
// sit side by side in the same timing chains.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } counter_state_e;

endpackage : counter_pkg

// File: rtl/down_counter_if.sv
// Control and status bundle for the down-counter.
// The master drives load/inhibit and observes the count; the slave is the counter.
interface down_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             clockinh;
    logic             load;
    logic [WIDTH-1:0] loadvalue;
    logic [WIDTH-1:0] countoutput;
    logic             borrowout;
    logic             running;

    modport master (
        output clockinh,
        output load,
        output loadvalue,
        input  countoutput,
        input  borrowout,
        input  running
    );

    modport slave (
        input  clockinh,
        input  load,
        input  loadvalue,
        output countoutput,
        output borrowout,
        output running
    );

endinterface : down_counter_if

// File: rtl/down_counter.sv
// Loadable down-counter with a one-cycle borrow pulse on expiry.
// AUTORELOAD=1 makes it a programmable-period tick generator (period is
// loadvalue+1 clocks); AUTORELOAD=0 makes it a one-shot timeout that halts
// at zero. A high clockinh freezes the count and suppresses borrow, which
// stretches the period one clock for every inhibited clock.
module down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit AUTORELOAD = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    down_counter_if.slave  bus
);

    counter_state_e   state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             borrow_q;
    logic             running_q;

    logic [WIDTH-1:0] count_dec;
    logic             count_zero;

    // Zero is detected before decrementing, so the wrapped value is never stored.
    assign count_dec  = count_q - WIDTH'(1);
    assign count_zero = (count_q == '0);

    // State machine with registered count, reload, borrow and running outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            borrow_q  <= 1'b0;
            running_q <= 1'b0;
        end else if (bus.load) begin
            reload_q  <= bus.loadvalue;
            count_q   <= bus.loadvalue;
            state_q   <= RUN;
            running_q <= 1'b1;
            borrow_q  <= 1'b0;
        end else if (bus.clockinh) begin
            borrow_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (count_zero) begin
                        borrow_q <= 1'b1;
                        if (AUTORELOAD) begin
                            count_q <= reload_q;
                        end else begin
                            state_q   <= HALT;
                            running_q <= 1'b0;
                        end
                    end else begin
                        count_q  <= count_dec;
                        borrow_q <= 1'b0;
                    end
                end
                default: begin
                    borrow_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.countoutput = count_q;
    assign bus.borrowout   = borrow_q;
    assign bus.running     = running_q;

endmodule : down_counter

// File: tb/tb_down_counter.sv
// Scoreboard bench for the down-counter. Two instances are driven with the
// same inputs: one with auto-reload, one in one-shot mode. Each stimulus
// vector pushes the hand-computed post-edge outputs of the instance it
// targets; a monitor pops and compares on the falling edge.
module tb_down_counter;
    import counter_pkg::*;

    localparam int W = 8;

    typedef struct {
        bit             sel;
        logic [W-1:0]   cnt;
        logic           bor;
        logic           run;
        int             id;
    } exp_t;

    logic clock;
    logic reset;

    down_counter_if #(.WIDTH(W)) ifAr ();
    down_counter_if #(.WIDTH(W)) ifOs ();

    exp_t expQ[$];
    int   checks;
    int   errors;
    int   stepNo;

    down_counter #(.WIDTH(W), .AUTORELOAD(1'b1)) dutAr (
        .clock (clock),
        .reset (reset),
        .bus   (ifAr.slave)
    );

    down_counter #(.WIDTH(W), .AUTORELOAD(1'b0)) dutOs (
        .clock (clock),
        .reset (reset),
        .bus   (ifOs.slave)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs to both instances and queue the expected outputs
    // of the selected instance after the next rising edge.
    task automatic applyStimulus(input bit sel, input logic rst, input logic ld,
                                 input logic [W-1:0] val, input logic inh,
                                 input logic [W-1:0] expCnt, input logic expBor,
                                 input logic expRun);
        exp_t e;
        @(negedge clock);
        reset          = rst;
        ifAr.load      = ld;
        ifOs.load      = ld;
        ifAr.loadvalue = val;
        ifOs.loadvalue = val;
        ifAr.clockinh  = inh;
        ifOs.clockinh  = inh;
        @(posedge clock);
        e.sel = sel;
        e.cnt = expCnt;
        e.bor = expBor;
        e.run = expRun;
        e.id  = stepNo;
        stepNo++;
        expQ.push_back(e);
    endtask

    // Compare one expected entry against the selected instance.
    task automatic checkOutput(input exp_t e);
        logic [W-1:0] aCnt;
        logic         aBor;
        logic         aRun;
        aCnt = e.sel ? ifOs.countoutput : ifAr.countoutput;
        aBor = e.sel ? ifOs.borrowout   : ifAr.borrowout;
        aRun = e.sel ? ifOs.running     : ifAr.running;
        checks++;
        if (aCnt !== e.cnt || aBor !== e.bor || aRun !== e.run) begin
            errors++;
            $display("[TB] FAIL step%0d %s: actual cnt=%0d bor=%b run=%b, required cnt=%0d bor=%b run=%b",
                     e.id, e.sel ? "oneshot" : "autoreload",
                     aCnt, aBor, aRun, e.cnt, e.bor, e.run);
        end
    endtask

    // Monitor: every falling edge, compare whatever results have been queued.
    initial begin
        forever begin
            @(negedge clock);
            while (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    // Directed scenarios with hand-computed expected values.
    initial begin
        checks        = 0;
        errors        = 0;
        stepNo        = 0;
        reset         = 1'b1;
        ifAr.load     = 1'b0;
        ifOs.load     = 1'b0;
        ifAr.loadvalue = '0;
        ifOs.loadvalue = '0;
        ifAr.clockinh = 1'b0;
        ifOs.clockinh = 1'b0;

        $display("[TB] reset then idle");
        repeat (2) applyStimulus(0, 1, 0, 8'd0, 0, 8'd0, 0, 0);
        repeat (5) applyStimulus(0, 0, 0, 8'd0, 0, 8'd0, 0, 0);

        $display("[TB] periodic load 3");
        applyStimulus(0, 0, 1, 8'd3, 0, 8'd3, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd2, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd1, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd0, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd3, 1, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd2, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd1, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd0, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd3, 1, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd2, 0, 1);

        $display("[TB] inhibit stretches period");
        applyStimulus(0, 0, 1, 8'd5, 0, 8'd5, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd4, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd3, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd2, 0, 1);
        repeat (3) applyStimulus(0, 0, 0, 8'd0, 1, 8'd2, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd1, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd0, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd5, 1, 1);

        $display("[TB] collisions");
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd4, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd3, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd2, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd1, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd0, 0, 1);
        applyStimulus(0, 0, 1, 8'd7, 0, 8'd7, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd6, 0, 1);
        applyStimulus(0, 1, 1, 8'd9, 0, 8'd0, 0, 0);
        applyStimulus(0, 0, 1, 8'd0, 0, 8'd0, 0, 1);
        repeat (4) applyStimulus(0, 0, 0, 8'd0, 0, 8'd0, 1, 1);
        applyStimulus(0, 0, 0, 8'd0, 1, 8'd0, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd0, 1, 1);
        applyStimulus(0, 0, 1, 8'd4, 1, 8'd4, 0, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'd3, 0, 1);

        $display("[TB] one-shot");
        applyStimulus(1, 1, 0, 8'd0, 0, 8'd0, 0, 0);
        applyStimulus(1, 0, 1, 8'd2, 0, 8'd2, 0, 1);
        applyStimulus(1, 0, 0, 8'd0, 0, 8'd1, 0, 1);
        applyStimulus(1, 0, 0, 8'd0, 0, 8'd0, 0, 1);
        applyStimulus(1, 0, 0, 8'd0, 0, 8'd0, 1, 0);
        repeat (10) applyStimulus(1, 0, 0, 8'd0, 0, 8'd0, 0, 0);
        applyStimulus(1, 0, 1, 8'd1, 0, 8'd1, 0, 1);
        applyStimulus(1, 0, 0, 8'd0, 0, 8'd0, 0, 1);
        applyStimulus(1, 0, 0, 8'd0, 0, 8'd0, 1, 0);
        applyStimulus(1, 0, 1, 8'd0, 0, 8'd0, 0, 1);
        applyStimulus(1, 0, 0, 8'd0, 0, 8'd0, 1, 0);
        applyStimulus(1, 0, 0, 8'd0, 0, 8'd0, 0, 0);

        $display("[TB] max value");
        applyStimulus(0, 1, 0, 8'd0, 0, 8'd0, 0, 0);
        applyStimulus(0, 0, 1, 8'hFF, 0, 8'hFF, 0, 1);
        for (int i = 1; i <= 255; i++) begin
            applyStimulus(0, 0, 0, 8'd0, 0, 8'(255 - i), 0, 1);
        end
        applyStimulus(0, 0, 0, 8'd0, 0, 8'hFF, 1, 1);
        applyStimulus(0, 0, 0, 8'd0, 0, 8'hFE, 0, 1);

        // Let the monitor drain the queue, bounded by a cycle budget.
        for (int k = 0; k < 10 && expQ.size() > 0; k++) begin
            @(negedge clock);
        end
        @(negedge clock);
        #1;
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: actual pending=%0d required pending=0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_down_counter
